// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: parametrised Fibonacci/Galois LFSR with seed load, a sticky
// lockup detector and a valid/ready word-stream output (first bit in the MSB).
// Optional build macro LFSR_PERIOD_EN adds period_len/period_hit outputs that
// measure the number of steps taken to return to the last loaded seed.
module lfsr_stream_gen #(
   parameter int unsigned      WIDTH = 17,
   parameter logic [WIDTH-1:0] TAPS  = 17'h12000,
   parameter logic [WIDTH-1:0] SEED  = 17'h00001,
   parameter int unsigned      OUT_W = 8,
   parameter bit               MODE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [WIDTH-1:0] state_q,
`ifdef LFSR_PERIOD_EN
   output logic             lockup,
   output logic [WIDTH-1:0] period_len,
   output logic             period_hit
`else
   output logic             lockup
`endif
);

   localparam int unsigned    CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fsm_t;

   fsm_t             fsm_q;
   logic [WIDTH-1:0] lfsr_q;
   logic [OUT_W-1:0] word_q;
   logic [CNT_W-1:0] cnt_q;
   logic             valid_q;
   logic             lockup_q;

   logic [WIDTH-1:0] step_d;
   logic [OUT_W-1:0] word_d;
   logic [WIDTH-1:0] seed_d;
   logic             step_fire;

   // One LFSR advance; the bit leaving the register is state[WIDTH-1] in both forms.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      if (MODE) begin
         r = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
      end else begin
         r = {s[WIDTH-2:0], ^(s & TAPS)};
      end
      return r;
   endfunction

   // Next-state values shared by the FSM and the optional period counter.
   always_comb begin
      step_d    = lfsr_step(lfsr_q);
      word_d    = (word_q << 1) | OUT_W'(lfsr_q[WIDTH-1]);
      seed_d    = (seed_in == '0) ? SEED : seed_in;
      step_fire = (fsm_q == RUN) && !seed_load && en && (lfsr_q != '0);
   end

   // Control FSM, LFSR state, word packer and lockup flag; seed_load overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= IDLE;
         lfsr_q   <= SEED;
         word_q   <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         lockup_q <= 1'b0;
      end else if (seed_load) begin
         fsm_q    <= IDLE;
         lfsr_q   <= seed_d;
         word_q   <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (en) begin
                  fsm_q <= RUN;
               end
            end
            RUN: begin
               if (lfsr_q == '0) begin
                  // Stuck register: recover from SEED without stepping; bit count is kept.
                  lockup_q <= 1'b1;
                  lfsr_q   <= SEED;
               end else if (step_fire) begin
                  lfsr_q <= step_d;
                  word_q <= word_d;
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     valid_q <= 1'b1;
                     fsm_q   <= HOLD;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  fsm_q   <= en ? RUN : IDLE;
               end
            end
            default: begin
               fsm_q <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = valid_q;
   assign out_data  = word_q;
   assign state_q   = lfsr_q;
   assign lockup    = lockup_q;

`ifdef LFSR_PERIOD_EN
   logic [WIDTH-1:0] seed_q;
   logic [WIDTH-1:0] pcnt_q;
   logic [WIDTH-1:0] plen_q;
   logic             phit_q;

   // Step counter that reports its value whenever the register returns to the loaded seed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_q <= SEED;
         pcnt_q <= '0;
         plen_q <= '0;
         phit_q <= 1'b0;
      end else begin
         phit_q <= 1'b0;
         if (seed_load) begin
            seed_q <= seed_d;
            pcnt_q <= '0;
         end else if (step_fire) begin
            if (step_d == seed_q) begin
               phit_q <= 1'b1;
               plen_q <= pcnt_q + WIDTH'(1);
               pcnt_q <= '0;
            end else begin
               pcnt_q <= pcnt_q + WIDTH'(1);
            end
         end
      end
   end

   assign period_len = plen_q;
   assign period_hit = phit_q;
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb_lfsr_stream_gen: directed table-driven bench for lfsr_stream_gen
// (WIDTH=4, SEED=1). Main instance TAPS=C Fibonacci OUT_W=4; a Galois
// instance and a TAPS=0 OUT_W=8 instance cover the other corner cases.
module tb_lfsr_stream_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       sl;
   logic       rdy;
   logic [3:0] seed;

   logic       v_m, v_g, v_z;
   logic [3:0] d_m, d_g;
   logic [7:0] d_z;
   logic [3:0] st_m, st_g, st_z;
   logic       lk_m, lk_g, lk_z;
`ifdef LFSR_PERIOD_EN
   logic [3:0] plen_m, plen_g, plen_z;
   logic       phit_m, phit_g, phit_z;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lfsr_stream_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4), .MODE(1'b0)) dut_m (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(sl), .seed_in(seed),
      .out_valid(v_m), .out_ready(rdy), .out_data(d_m), .state_q(st_m),
`ifdef LFSR_PERIOD_EN
      .lockup(lk_m), .period_len(plen_m), .period_hit(phit_m)
`else
      .lockup(lk_m)
`endif
   );

   lfsr_stream_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4), .MODE(1'b1)) dut_g (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(sl), .seed_in(seed),
      .out_valid(v_g), .out_ready(rdy), .out_data(d_g), .state_q(st_g),
`ifdef LFSR_PERIOD_EN
      .lockup(lk_g), .period_len(plen_g), .period_hit(phit_g)
`else
      .lockup(lk_g)
`endif
   );

   lfsr_stream_gen #(.WIDTH(4), .TAPS(4'h0), .SEED(4'h1), .OUT_W(8), .MODE(1'b0)) dut_z (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(sl), .seed_in(seed),
      .out_valid(v_z), .out_ready(rdy), .out_data(d_z), .state_q(st_z),
`ifdef LFSR_PERIOD_EN
      .lockup(lk_z), .period_len(plen_z), .period_hit(phit_z)
`else
      .lockup(lk_z)
`endif
   );

   typedef struct {
      bit         rst;
      bit         en;
      bit         rdy;
      bit         sl;
      logic [3:0] seed;
      bit         v;
      logic [3:0] d;
      logic [3:0] st;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, bit e, bit rd, bit s, logic [3:0] sd,
                               bit v, logic [3:0] d, logic [3:0] st);
      vec_t x;
      x.rst = r; x.en = e; x.rdy = rd; x.sl = s; x.seed = sd;
      x.v = v; x.d = d; x.st = st;
      tbl.push_back(x);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input bit e, input bit rd, input bit s, input logic [3:0] sd);
      en = e; rdy = rd; sl = s; seed = sd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      en = 1'b0; rdy = 1'b0; sl = 1'b0; seed = 4'h0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b0; rdy = 1'b0; sl = 1'b0; seed = 4'h0;

      // Test 1: free run with ready=1.
      add(1,0,0,0,4'h0, 0,4'h0,4'h1);
      add(0,1,1,0,4'h0, 0,4'h0,4'h1);
      add(0,1,1,0,4'h0, 0,4'h0,4'h2);
      add(0,1,1,0,4'h0, 0,4'h0,4'h4);
      add(0,1,1,0,4'h0, 0,4'h0,4'h9);
      add(0,1,1,0,4'h0, 1,4'h1,4'h3);
      add(0,1,1,0,4'h0, 0,4'h0,4'h3);
      add(0,1,1,0,4'h0, 0,4'h0,4'h6);
      add(0,1,1,0,4'h0, 0,4'h0,4'hD);
      add(0,1,1,0,4'h0, 0,4'h0,4'hA);
      add(0,1,1,0,4'h0, 1,4'h3,4'h5);
      // Test 2: backpressure for 10 cycles on the first word.
      add(1,0,0,0,4'h0, 0,4'h0,4'h1);
      add(0,1,0,0,4'h0, 0,4'h0,4'h1);
      add(0,1,0,0,4'h0, 0,4'h0,4'h2);
      add(0,1,0,0,4'h0, 0,4'h0,4'h4);
      add(0,1,0,0,4'h0, 0,4'h0,4'h9);
      add(0,1,0,0,4'h0, 1,4'h1,4'h3);
      for (int i = 0; i < 10; i++) add(0,1,0,0,4'h0, 1,4'h1,4'h3);
      add(0,1,1,0,4'h0, 0,4'h0,4'h3);
      add(0,1,1,0,4'h0, 0,4'h0,4'h6);
      add(0,1,1,0,4'h0, 0,4'h0,4'hD);
      add(0,1,1,0,4'h0, 0,4'h0,4'hA);
      add(0,1,1,0,4'h0, 1,4'h3,4'h5);
      // Test 3: seed loads mid-word (zero seed), fresh seed 9, and during HOLD.
      add(1,0,0,0,4'h0, 0,4'h0,4'h1);
      add(0,1,0,0,4'h0, 0,4'h0,4'h1);
      add(0,1,0,0,4'h0, 0,4'h0,4'h2);
      add(0,1,0,0,4'h0, 0,4'h0,4'h4);
      add(0,1,0,1,4'h0, 0,4'h0,4'h1);
      add(0,1,0,0,4'h0, 0,4'h0,4'h1);
      add(0,1,0,0,4'h0, 0,4'h0,4'h2);
      add(0,1,0,1,4'h9, 0,4'h0,4'h9);
      add(0,1,0,0,4'h0, 0,4'h0,4'h9);
      add(0,1,0,0,4'h0, 0,4'h0,4'h3);
      add(0,1,0,0,4'h0, 0,4'h0,4'h6);
      add(0,1,0,0,4'h0, 0,4'h0,4'hD);
      add(0,1,0,0,4'h0, 1,4'h9,4'hA);
      add(0,1,0,0,4'h0, 1,4'h9,4'hA);
      add(0,1,0,1,4'h5, 0,4'h0,4'h5);
      add(0,0,1,0,4'h0, 0,4'h0,4'h5);
      // Test 4: enable toggling every cycle.
      add(1,0,0,0,4'h0, 0,4'h0,4'h1);
      add(0,1,1,0,4'h0, 0,4'h0,4'h1);
      add(0,0,1,0,4'h0, 0,4'h0,4'h1);
      add(0,1,1,0,4'h0, 0,4'h0,4'h2);
      add(0,0,1,0,4'h0, 0,4'h0,4'h2);
      add(0,1,1,0,4'h0, 0,4'h0,4'h4);
      add(0,0,1,0,4'h0, 0,4'h0,4'h4);
      add(0,1,1,0,4'h0, 0,4'h0,4'h9);
      add(0,0,1,0,4'h0, 0,4'h0,4'h9);
      add(0,1,1,0,4'h0, 1,4'h1,4'h3);
      add(0,0,1,0,4'h0, 0,4'h0,4'h3);
      add(0,0,1,0,4'h0, 0,4'h0,4'h3);

      @(negedge clk);
      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            en = 1'b0; rdy = 1'b0; sl = 1'b0; seed = 4'h0;
            rst_n = 1'b0;
            #1;
            check($sformatf("v%0d.rst_state", i), 32'(st_m), 32'(tbl[i].st));
            check($sformatf("v%0d.rst_valid", i), 32'(v_m), 32'(tbl[i].v));
            check($sformatf("v%0d.rst_data", i), 32'(d_m), 32'(tbl[i].d));
            check($sformatf("v%0d.rst_lockup", i), 32'(lk_m), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            cyc(tbl[i].en, tbl[i].rdy, tbl[i].sl, tbl[i].seed);
            check($sformatf("v%0d.state", i), 32'(st_m), 32'(tbl[i].st));
            check($sformatf("v%0d.valid", i), 32'(v_m), 32'(tbl[i].v));
            if (tbl[i].v) check($sformatf("v%0d.data", i), 32'(d_m), 32'(tbl[i].d));
            check($sformatf("v%0d.lockup", i), 32'(lk_m), 32'd0);
         end
      end

      // Galois form: words 1 then B.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'h0);
      check("gal.valid1", 32'(v_g), 32'd1);
      check("gal.data1", 32'(d_g), 32'h1);
      check("gal.state1", 32'(st_g), 32'hC);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'h0);
      check("gal.valid2", 32'(v_g), 32'd1);
      check("gal.data2", 32'(d_g), 32'hB);
      check("gal.state2", 32'(st_g), 32'h4);

      // Zero taps: lockup detection, SEED reload, sticky flag, clear on seed_load.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'h0);
      check("lock.zero_state", 32'(st_z), 32'h0);
      check("lock.not_yet", 32'(lk_z), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 4'h0);
      check("lock.set", 32'(lk_z), 32'd1);
      check("lock.reload", 32'(st_z), 32'h1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 4'h0);
      check("lock.sticky", 32'(lk_z), 32'd1);
      check("lock.state8", 32'(st_z), 32'h8);
      check("lock.no_word", 32'(v_z), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 4'h0);
      check("lock.word_valid", 32'(v_z), 32'd1);
      check("lock.word_data", 32'(d_z), 32'h11);
      cyc(1'b1, 1'b1, 1'b0, 4'h0);
      cyc(1'b1, 1'b1, 1'b0, 4'h0);
      check("lock.reload2", 32'(st_z), 32'h1);
      cyc(1'b1, 1'b1, 1'b1, 4'h0);
      check("lock.cleared", 32'(lk_z), 32'd0);
      check("lock.seed_state", 32'(st_z), 32'h1);

`ifdef LFSR_PERIOD_EN
      begin
         bit seen;
         seen = 1'b0;
         do_reset();
         for (int i = 0; i < 200 && !seen; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'h0);
            if (phit_m) seen = 1'b1;
         end
         check("period.hit", 32'(seen), 32'd1);
         check("period.len", 32'(plen_m), 32'd15);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
